// File: rtl/eink_line_feeder_if.sv
// Bundles the pixel-in, word-out and frame-control signals of the e-ink line feeder.
// The master side drives frame control, pixels and pop requests; the slave side is the feeder.
interface eink_line_feeder_if;
   logic        frame_fresh;
   logic [3:0]  frame_phase;
   logic [9:0]  line_words;
   logic [9:0]  line_num;
   logic        pix_valid;
   logic        pix_ready;
   logic [3:0]  pix_old;
   logic [3:0]  pix_new;
   logic        word_req;
   logic [15:0] data;
   logic        line_end;
   logic        frame_busy;
   logic        underrun;

   modport master (
      output frame_fresh, frame_phase, line_words, line_num,
      output pix_valid, pix_old, pix_new, word_req,
      input  pix_ready, data, line_end, frame_busy, underrun
   );

   modport slave (
      input  frame_fresh, frame_phase, line_words, line_num,
      input  pix_valid, pix_old, pix_new, word_req,
      output pix_ready, data, line_end, frame_busy, underrun
   );
endinterface

// File: rtl/eink_line_feeder.sv
// E-ink line feeder: maps old/new gray pixel pairs to 2-bit drive codes, packs eight
// codes per 16-bit word, buffers words in a FIFO and hands one out per word_req.
// A completed word sits in a one-entry staging register for one cycle before it is
// written to the FIFO, so it becomes poppable the cycle after the 8th pixel edge.
module eink_line_feeder #(
   parameter int FIFO_DEPTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   eink_line_feeder_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [3:0]      phase_q;
   logic [9:0]      lw_q, ln_q;
   logic [2:0]      pix_cnt_q;
   logic [13:0]     shreg_q;
   logic [9:0]      word_cnt_q, line_cnt_q;
   logic            pend_q, pend_last_q;
   logic [15:0]     pend_word_q;
   logic [15:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic [15:0]     data_q;
   logic            line_end_q, underrun_q;

   logic            pix_ready, pix_fire, push, pop_ok, pop_under;
   logic            last_word, last_line;
   logic [3:0]      diff;
   logic [1:0]      code;
   logic [15:0]     word_full;

   // Handshake, drive-code and FIFO-event decode
   always_comb begin
      pix_ready = (state_q == S_RUN) && (count_q < DEPTH_C);
      pix_fire  = bus.pix_valid && pix_ready && !bus.frame_fresh;
      push      = pend_q && !bus.frame_fresh;
      pop_ok    = bus.word_req && (count_q != '0) && !bus.frame_fresh;
      pop_under = bus.word_req && (count_q == '0) && !bus.frame_fresh;
      diff      = (bus.pix_new > bus.pix_old) ? (bus.pix_new - bus.pix_old)
                                              : (bus.pix_old - bus.pix_new);
      code      = 2'b00;
      if (phase_q < diff) begin
         if (bus.pix_new < bus.pix_old)      code = 2'b01;
         else if (bus.pix_new > bus.pix_old) code = 2'b10;
      end
      word_full = {shreg_q, code};
      last_word = (word_cnt_q == lw_q - 10'd1);
      last_line = (line_cnt_q == ln_q - 10'd1);
   end

   // Next-state logic: frame_fresh always restarts the frame
   always_comb begin
      state_d = state_q;
      if (bus.frame_fresh) begin
         state_d = S_RUN;
      end else begin
         unique case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (pix_fire && pix_cnt_q == 3'd7 && last_word && last_line)
                        state_d = S_DRAIN;
            S_DRAIN: if (count_q == '0 && !pend_q)
                        state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FIFO storage; no reset so it can map to block RAM
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= pend_word_q;
   end

   // Packing, counters, FIFO pointers and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= '0;
         lw_q        <= '0;
         ln_q        <= '0;
         pix_cnt_q   <= '0;
         shreg_q     <= '0;
         word_cnt_q  <= '0;
         line_cnt_q  <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         pend_word_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_q      <= '0;
         line_end_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else if (bus.frame_fresh) begin
         phase_q     <= bus.frame_phase;
         lw_q        <= bus.line_words;
         ln_q        <= bus.line_num;
         pix_cnt_q   <= '0;
         shreg_q     <= '0;
         word_cnt_q  <= '0;
         line_cnt_q  <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         line_end_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         line_end_q <= 1'b0;
         // staged word moves into the FIFO one cycle after its 8th pixel
         if (push) begin
            pend_q     <= 1'b0;
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            line_end_q <= pend_last_q;
         end
         if (pix_fire) begin
            pix_cnt_q <= pix_cnt_q + 3'd1;
            if (pix_cnt_q == 3'd7) begin
               pend_q      <= 1'b1;
               pend_word_q <= word_full;
               pend_last_q <= last_word;
               shreg_q     <= '0;
               if (last_word) begin
                  word_cnt_q <= '0;
                  line_cnt_q <= line_cnt_q + 10'd1;
               end else begin
                  word_cnt_q <= word_cnt_q + 10'd1;
               end
            end else begin
               shreg_q <= {shreg_q[11:0], code};
            end
         end
         if (pop_ok) begin
            data_q   <= mem[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (pop_under) begin
            data_q     <= 16'h0000;
            underrun_q <= 1'b1;
         end
         unique case ({push, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.pix_ready  = pix_ready;
   assign bus.data       = data_q;
   assign bus.line_end   = line_end_q;
   assign bus.frame_busy = (state_q != S_IDLE);
   assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_eink_line_feeder.sv
// Directed/randomized bench for eink_line_feeder with a queue-based reference model.
module tb_eink_line_feeder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   eink_line_feeder_if bus();

   eink_line_feeder #(.FIFO_DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int le_cnt = 0;

   // reference model state
   logic [15:0] exp_q[$];
   int          m_phase;
   int          m_pcnt;
   logic [15:0] m_word;
   logic        m_under;

   always @(negedge clk) if (bus.line_end === 1'b1) le_cnt++;

   function automatic logic [1:0] code_of(int ph, int o, int n);
      int d;
      d = (n > o) ? n - o : o - n;
      if (ph < d) return (n < o) ? 2'b01 : 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fresh(input int ph, input int lw, input int ln);
      bus.frame_fresh = 1'b1;
      bus.frame_phase = 4'(ph);
      bus.line_words  = 10'(lw);
      bus.line_num    = 10'(ln);
      tick();
      bus.frame_fresh = 1'b0;
      exp_q.delete();
      m_phase = ph;
      m_pcnt  = 0;
      m_word  = '0;
      m_under = 1'b0;
      le_cnt  = 0;
   endtask

   task automatic send_pix(input int o, input int n);
      int waitc;
      waitc = 0;
      bus.pix_valid = 1'b1;
      bus.pix_old   = 4'(o);
      bus.pix_new   = 4'(n);
      while (bus.pix_ready !== 1'b1 && waitc < 200) begin
         tick();
         waitc++;
      end
      if (waitc >= 200) begin
         total++;
         bad++;
         $display("FAIL pix_accept_timeout observed=pix_ready_low expected=accept");
         bus.pix_valid = 1'b0;
      end else begin
         tick();
         bus.pix_valid = 1'b0;
         m_word = m_word | (16'(code_of(m_phase, o, n)) << (14 - 2 * m_pcnt));
         m_pcnt++;
         if (m_pcnt == 8) begin
            exp_q.push_back(m_word);
            m_word = '0;
            m_pcnt = 0;
         end
      end
   endtask

   task automatic send_rand(input int cnt);
      for (int i = 0; i < cnt; i++) send_pix($urandom_range(0, 15), $urandom_range(0, 15));
   endtask

   // pop one word and compare against the model
   task automatic pop_chk(input string tag);
      logic [15:0] e;
      tick();
      tick();
      bus.word_req = 1'b1;
      tick();
      bus.word_req = 1'b0;
      if (exp_q.size() == 0) begin
         e = 16'h0000;
         m_under = 1'b1;
      end else begin
         e = exp_q.pop_front();
      end
      chk(tag, 32'(bus.data), 32'(e));
      chk({tag, "_underrun"}, 32'(bus.underrun), 32'(m_under));
      $display("pop %s data=%h expected=%h", tag, bus.data, e);
   endtask

   int mo[8];
   int mn[8];

   initial begin
      bus.frame_fresh = 0; bus.frame_phase = 0; bus.line_words = 0; bus.line_num = 0;
      bus.pix_valid = 0; bus.pix_old = 0; bus.pix_new = 0; bus.word_req = 0;
      m_phase = 0; m_pcnt = 0; m_word = 0; m_under = 0;
      #2;
      chk("rst_pix_ready", 32'(bus.pix_ready), 0);
      chk("rst_data", 32'(bus.data), 0);
      chk("rst_line_end", 32'(bus.line_end), 0);
      chk("rst_frame_busy", 32'(bus.frame_busy), 0);
      chk("rst_underrun", 32'(bus.underrun), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("idle_pix_ready", 32'(bus.pix_ready), 0);

      // basic single-word frame
      fresh(0, 1, 1);
      chk("run_busy", 32'(bus.frame_busy), 1);
      chk("run_ready", 32'(bus.pix_ready), 1);
      for (int i = 0; i < 8; i++) send_pix(15, 0);
      tick(); tick();
      chk("basic_line_end_cnt", 32'(le_cnt), 1);
      chk("drain_busy", 32'(bus.frame_busy), 1);
      chk("drain_ready", 32'(bus.pix_ready), 0);
      pop_chk("basic_word");
      chk("basic_literal", 32'(bus.data), 32'h5555);
      tick();
      chk("busy_fall", 32'(bus.frame_busy), 0);

      // phase boundary d=3
      fresh(2, 1, 1);
      for (int i = 0; i < 8; i++) send_pix(4, 7);
      pop_chk("phase2_word");
      chk("phase2_literal", 32'(bus.data), 32'hAAAA);
      fresh(3, 1, 1);
      for (int i = 0; i < 8; i++) send_pix(4, 7);
      pop_chk("phase3_word");

      // mixed word at phase 0
      mo = '{15, 0, 5, 9, 15, 0, 5, 9};
      mn = '{0, 15, 5, 8, 0, 15, 5, 8};
      fresh(0, 1, 1);
      for (int i = 0; i < 8; i++) send_pix(mo[i], mn[i]);
      pop_chk("mixed_word");

      // random frame: 3 words/line, 2 lines
      fresh($urandom_range(0, 15), 3, 2);
      send_rand(48);
      tick(); tick();
      chk("rand_line_end_cnt", 32'(le_cnt), 2);
      chk("rand_ready_after_last", 32'(bus.pix_ready), 0);
      for (int w = 0; w < 6; w++) pop_chk("rand_word");
      tick();
      chk("rand_busy_fall", 32'(bus.frame_busy), 0);
      pop_chk("rand_extra_underrun");

      // backpressure
      fresh(0, 16, 1);
      send_rand(64);
      tick(); tick(); tick();
      chk("bp_ready_low", 32'(bus.pix_ready), 0);
      pop_chk("bp_word");
      chk("bp_ready_back", 32'(bus.pix_ready), 1);

      // underrun behaviour
      fresh(0, 2, 1);
      pop_chk("ur_empty_pop");
      send_rand(8);
      tick(); tick();
      chk("ur_sticky", 32'(bus.underrun), 1);
      pop_chk("ur_word_after");
      fresh(0, 2, 1);
      chk("ur_cleared", 32'(bus.underrun), 0);

      // restart mid-word
      fresh(0, 1, 1);
      send_rand(3);
      fresh($urandom_range(0, 15), 1, 1);
      pop_chk("restart_empty");
      send_rand(8);
      pop_chk("restart_clean_word");

      // async reset mid-line with 4 words queued
      fresh(0, 8, 1);
      send_rand(32);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pix_ready", 32'(bus.pix_ready), 0);
      chk("arst_data", 32'(bus.data), 0);
      chk("arst_line_end", 32'(bus.line_end), 0);
      chk("arst_frame_busy", 32'(bus.frame_busy), 0);
      chk("arst_underrun", 32'(bus.underrun), 0);
      tick();
      rst_n = 1'b1;
      exp_q.delete(); m_pcnt = 0; m_word = 0; m_under = 0;
      tick(); tick();
      chk("arst_idle_ready", 32'(bus.pix_ready), 0);
      fresh(1, 1, 1);
      send_rand(8);
      pop_chk("post_reset_word");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute time guard
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
